prog_counter: RTL and testbench

- Parametrised, programmable successor to the free-running 8-bit top-level counter.
- Adds count enable, programmable prescaler, synchronous load, programmable terminal value (limit) and four count modes: wrap-up, wrap-down, ping-pong and one-shot.
- Drives a registered count bus plus terminal-count, direction and running status flags.
- Sits directly under the top-level wrapper, with ui_in/uio_in supplying control and uo_out carrying the count.

---
 rtl/prog_counter.sv | 155 +++++++++++++++
 tb/tb_prog_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable counter: prescaled tick, load, limit, up/down/ping-pong/one-shot modes.
// One-cycle latency from tick or load to count/tc; no backpressure (en holds the prescaler and the counter).
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  dir,
  output logic                  running
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_ONE  = 2'b11
  } mode_e;

  mode_e                 mode_s;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  tc_q, tc_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic [WIDTH-1:0]      load_clamped;
  logic [WIDTH-1:0]      cnt_inc;
  logic [WIDTH-1:0]      cnt_dec;
  logic                  at_limit;
  logic                  at_zero;

  assign mode_s       = mode_e'(mode);
  // A prescale lowered below psc must still tick, hence >= rather than ==.
  assign tick         = en && (psc_q >= prescale);
  assign load_clamped = (load_val > limit) ? limit : load_val;
  assign cnt_inc      = count_q + WIDTH'(1);
  assign cnt_dec      = count_q - WIDTH'(1);
  assign at_limit     = (count_q >= limit);
  assign at_zero      = (count_q == '0);

  always_comb begin
    psc_d = psc_q;
    if (load || tick) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = psc_q + PRESCALE_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    done_d  = done_q;
    if (load) begin
      count_d = load_clamped;
      dir_d   = 1'b1;
      done_d  = (mode_s == MODE_ONE) && (load_clamped == limit);
    end else if (tick) begin
      case (mode_s)
        MODE_UP: begin
          if (at_limit) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = cnt_inc;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            count_d = limit;
            tc_d    = 1'b1;
          end else begin
            count_d = cnt_dec;
          end
        end
        MODE_PP: begin
          if (dir_q) begin
            if (at_limit) begin
              // count can only be zero here when limit is zero; stay put then.
              dir_d   = 1'b0;
              count_d = at_zero ? '0 : cnt_dec;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_inc;
            end
          end else begin
            if (at_zero) begin
              dir_d   = 1'b1;
              count_d = (limit == '0) ? '0 : cnt_inc;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_dec;
            end
          end
        end
        MODE_ONE: begin
          if (!done_q) begin
            if (cnt_inc >= limit) begin
              count_d = limit;
              done_d  = 1'b1;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
    if (mode_s != MODE_ONE) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dir = 1'b1;
    case (mode_s)
      MODE_DOWN: dir = 1'b0;
      MODE_PP:   dir = dir_q;
      default:   dir = 1'b1;
    endcase
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = !((mode_s == MODE_ONE) && done_q);

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: behavioural model checked every cycle plus hand-computed directed checkpoints.
`timescale 1ns/100ps
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       dir;
  logic       running;

  prog_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .dir      (dir),
    .running  (running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer state following the counting rules directly.
  int m_count = 0;
  int m_psc   = 0;
  int m_dir   = 1;
  int m_done  = 0;
  int m_tc    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_psc = 0; m_dir = 1; m_done = 0; m_tc = 0;
    end else begin
      int lim, lv, ps;
      bit tk;
      lim  = int'(limit);
      lv   = int'(load_val);
      ps   = int'(prescale);
      tk   = en && (m_psc >= ps);
      m_tc = 0;
      if (load) begin
        m_count = (lv < lim) ? lv : lim;
        m_psc   = 0;
        m_dir   = 1;
        m_done  = (mode == 2'd3 && m_count == lim) ? 1 : 0;
      end else begin
        if (en) m_psc = tk ? 0 : m_psc + 1;
        if (tk) begin
          case (mode)
            2'd0: if (m_count >= lim) begin m_count = 0; m_tc = 1; end
                  else m_count = m_count + 1;
            2'd1: if (m_count == 0) begin m_count = lim; m_tc = 1; end
                  else m_count = m_count - 1;
            2'd2: begin
              if (m_dir == 1) begin
                if (m_count >= lim) begin
                  m_dir = 0; m_tc = 1;
                  m_count = (m_count == 0) ? 0 : m_count - 1;
                end else m_count = m_count + 1;
              end else begin
                if (m_count == 0) begin
                  m_dir = 1; m_tc = 1;
                  m_count = (lim == 0) ? 0 : 1;
                end else m_count = m_count - 1;
              end
            end
            default: if (m_done == 0) begin
              if (((m_count + 1) % 256) >= lim) begin
                m_count = lim; m_done = 1; m_tc = 1;
              end else m_count = (m_count + 1) % 256;
            end
          endcase
        end
      end
      if (mode != 2'd3) m_done = 0;
    end
  end

  always @(negedge clk) begin
    int exp_dir;
    exp_dir = (mode == 2'd1) ? 0 : (mode == 2'd2) ? m_dir : 1;
    chk("model_count",   count,   m_count);
    chk("model_tc",      tc,      m_tc);
    chk("model_dir",     dir,     exp_dir);
    chk("model_running", running, (mode == 2'd3 && m_done == 1) ? 0 : 1);
  end

  // Advance n clocks; returns just after the negedge compare so inputs can change safely.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0;
    load_val = 8'd0; limit = 8'd5; prescale = 8'd0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_dir", dir, 1);
    chk("rst_running", running, 1);
    cyc(1);
    rst_n = 1'b1; en = 1'b1;

    // wrap-up, limit 5, prescale 0
    cyc(5); chk("up_c5", count, 5); chk("up_tc5", tc, 0);
    cyc(1); chk("up_wrap", count, 0); chk("up_wrap_tc", tc, 1);
    cyc(1); chk("up_c1", count, 1); chk("up_tc1", tc, 0);
    cyc(2); chk("up_c3", count, 3);

    // asynchronous reset pulse mid-count, no clock edge involved
    rst_n = 1'b0;
    #0.5;
    chk("arst_count", count, 0);
    chk("arst_tc", tc, 0);
    chk("arst_dir", dir, 1);
    chk("arst_running", running, 1);
    #0.5;
    rst_n = 1'b1;
    cyc(1); chk("arst_restart", count, 1);

    // prescale 2 and enable gating
    prescale = 8'd2;
    cyc(2); chk("psc_hold", count, 1);
    cyc(1); chk("psc_tick", count, 2);
    cyc(1);
    en = 1'b0;
    cyc(4); chk("en_hold", count, 2);
    en = 1'b1;
    cyc(1); chk("en_resume_wait", count, 2);
    cyc(1); chk("en_resume_tick", count, 3);

    // ping-pong, limit 3
    prescale = 8'd0; mode = 2'd2; limit = 8'd3; load = 1'b1; load_val = 8'd0;
    cyc(1); load = 1'b0; chk("pp_load", count, 0);
    cyc(3); chk("pp_top", count, 3); chk("pp_top_dir", dir, 1);
    cyc(1); chk("pp_turn_dn", count, 2); chk("pp_turn_dn_tc", tc, 1); chk("pp_dir0", dir, 0);
    cyc(2); chk("pp_bottom", count, 0); chk("pp_bottom_tc", tc, 0);
    cyc(1); chk("pp_turn_up", count, 1); chk("pp_turn_up_tc", tc, 1); chk("pp_dir1", dir, 1);

    // one-shot, limit 4
    mode = 2'd3; limit = 8'd4; load = 1'b1; load_val = 8'd0;
    cyc(1); load = 1'b0; chk("os_load", count, 0);
    cyc(3); chk("os_c3", count, 3); chk("os_run3", running, 1);
    cyc(1); chk("os_end", count, 4); chk("os_end_tc", tc, 1); chk("os_done", running, 0);
    cyc(2); chk("os_hold", count, 4); chk("os_hold_tc", tc, 0); chk("os_hold_run", running, 0);
    load = 1'b1; load_val = 8'd2;
    cyc(1); load = 1'b0; chk("os_reload", count, 2); chk("os_rerun", running, 1);
    cyc(1); chk("os_c3b", count, 3);
    cyc(1); chk("os_end2", count, 4); chk("os_end2_tc", tc, 1);

    // wrap-down from 0, limit 7
    mode = 2'd1; limit = 8'd7; load = 1'b1; load_val = 8'd0;
    cyc(1); load = 1'b0; chk("dn_load", count, 0); chk("dn_running", running, 1);
    cyc(1); chk("dn_wrap", count, 7); chk("dn_wrap_tc", tc, 1); chk("dn_dir", dir, 0);

    // load colliding with a tick, clamped to limit
    mode = 2'd0; limit = 8'd100; load = 1'b1; load_val = 8'd200;
    cyc(1); load = 1'b0; chk("ld_clamp", count, 100); chk("ld_clamp_tc", tc, 0);
    cyc(1); chk("ld_wrap", count, 0); chk("ld_wrap_tc", tc, 1);

    // load clears the prescaler mid-period
    prescale = 8'd2;
    cyc(1); load = 1'b1; load_val = 8'd50;
    cyc(1); load = 1'b0; chk("ldpsc_load", count, 50);
    cyc(2); chk("ldpsc_wait", count, 50);
    cyc(1); chk("ldpsc_tick", count, 51);

    // limit at all-ones
    prescale = 8'd0; limit = 8'd255; load = 1'b1; load_val = 8'd254;
    cyc(1); load = 1'b0; chk("max_load", count, 254);
    cyc(1); chk("max_top", count, 255); chk("max_top_tc", tc, 0);
    cyc(1); chk("max_wrap", count, 0); chk("max_wrap_tc", tc, 1);

    // lowered limit while counting down, then lowered prescale forcing a tick
    mode = 2'd1; load = 1'b1; load_val = 8'd20;
    cyc(1); load = 1'b0; limit = 8'd10;
    cyc(1); chk("low_lim_dec", count, 19);
    prescale = 8'd9; mode = 2'd0;
    cyc(3); chk("psc9_hold", count, 19);
    prescale = 8'd1;
    cyc(1); chk("psc_lowered", count, 0); chk("psc_lowered_tc", tc, 1);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
